// File: rtl/ram_backend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_backend (plus common_types_pkg)                             |
// | Purpose  : Word-organised on-chip RAM behind the AHB memory controller.    |
// |            Each access is modelled as FREE -> BUSY (LAT cycles) -> ACCESS  |
// |            -> DONE. Read data is registered on load.                       |
// | Ports    : clk   - system clock, rising edge                               |
// |            nrst  - asynchronous active-low reset                           |
// |            ren   - read request                                            |
// |            wen   - byte write strobes (bit i writes store[8i+7:8i])        |
// |            addr  - byte address, word index addr[$clog2(DEPTH)+1:2]        |
// |            store - write data                                              |
// |            load  - registered read data                                    |
// |            state - access progress (ram_state_t)                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package common_types_pkg;
  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_DONE   = 2'd3
  } ram_state_t;
endpackage

module ram_backend
  import common_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ren,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] store,
  output logic [31:0] load,
  output ram_state_t  state
);

  localparam int unsigned C_AW       = $clog2(DEPTH);
  localparam logic [3:0]  C_CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("ram_backend: DEPTH must be a power of two");
  end
  if (LAT > 15) begin : g_lat_chk
    $error("ram_backend: LAT must be in 0..15");
  end

  logic [31:0]     r_mem [DEPTH];
  ram_state_t      r_state;
  ram_state_t      w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_op_wr;
  logic [C_AW-1:0] r_idx;
  logic [3:0]      r_wen;
  logic [31:0]     r_store;
  logic [31:0]     r_load;

  logic            w_req;
  logic [C_AW-1:0] w_idx;
  logic            w_unused;

  assign w_req    = ren | (|wen);
  // Upper address bits alias onto the same words; byte offset is ignored.
  assign w_idx    = addr[C_AW+1:2];
  assign w_unused = ^{addr[31:C_AW+2], addr[1:0]};

  assign state = r_state;
  assign load  = r_load;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RAM_FREE: begin
        if (w_req) begin
          if (LAT > 0) begin
            w_state_nxt = RAM_BUSY;
            w_cnt_nxt   = C_CNT_INIT;
          end else begin
            w_state_nxt = RAM_ACCESS;
          end
        end
      end
      RAM_BUSY: begin
        // A dropped request aborts before the array is touched.
        if (!w_req) begin
          w_state_nxt = RAM_FREE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = RAM_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RAM_ACCESS: w_state_nxt = RAM_DONE;
      RAM_DONE:   w_state_nxt = RAM_FREE;
      default:    w_state_nxt = RAM_FREE;
    endcase
  end

  // State, counter, latched request and read data register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= RAM_FREE;
      r_cnt   <= 4'd0;
      r_op_wr <= 1'b0;
      r_idx   <= '0;
      r_wen   <= 4'd0;
      r_store <= 32'd0;
      r_load  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == RAM_FREE && w_req) begin
        // Write wins when both a read and a write are requested.
        r_op_wr <= |wen;
        r_idx   <= w_idx;
        r_wen   <= wen;
        r_store <= store;
      end
      if (r_state == RAM_ACCESS && !r_op_wr) begin
        r_load <= r_mem[r_idx];
      end
    end
  end

  // Array write; contents are deliberately not reset. Reset forces FREE, so
  // an interrupted write can never reach this point.
  always_ff @(posedge clk) begin
    if (r_state == RAM_ACCESS && r_op_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wen[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_store[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_backend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_backend                                                  |
// | Purpose  : Self-checking bench for ram_backend (LAT=2 and LAT=0 copies).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ram_backend;
  import common_types_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ren,  ren0;
  logic [3:0]  wen,  wen0;
  logic [31:0] addr, addr0, store, store0;
  logic [31:0] load, load0;
  ram_state_t  state, state0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_backend #(.DEPTH(4096), .LAT(2)) dut (
    .clk(clk), .nrst(nrst), .ren(ren), .wen(wen), .addr(addr),
    .store(store), .load(load), .state(state)
  );

  ram_backend #(.DEPTH(4096), .LAT(0)) dut0 (
    .clk(clk), .nrst(nrst), .ren(ren0), .wen(wen0), .addr(addr0),
    .store(store0), .load(load0), .state(state0)
  );

  typedef struct {
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] store;
    ram_state_t  st;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One LAT=2 transfer from FREE; returns load seen in the DONE cycle.
  task automatic run_op(input logic r, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] ld_done);
    int n;
    n = 0;
    ren = r; wen = w; addr = a; store = d;
    while (state != RAM_DONE && n < 20) begin
      step();
      n++;
    end
    chk("latency_lat2", 32'(n), 32'd4);
    ld_done = load;
    ren = 1'b0; wen = 4'd0;
    step();
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    ren0 = 1'b0; wen0 = 4'hF; addr0 = a; store0 = d;
    while (state0 != RAM_DONE && n < 10) begin
      step();
      n++;
    end
    chk("latency_lat0", 32'(n), 32'd2);
    wen0 = 4'd0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ld;
    ram_state_t  exp_st0 [6];
    logic [31:0] exp_ld0 [6];

    vecs[0]  = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, RAM_FREE,   32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, RAM_BUSY,   32'h0};
    vecs[2]  = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, RAM_BUSY,   32'h0};
    vecs[3]  = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, RAM_ACCESS, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h10, 32'h0,        RAM_DONE,   32'h0};
    vecs[5]  = '{1'b1, 4'h0, 32'h10, 32'h0,        RAM_FREE,   32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h10, 32'h0,        RAM_BUSY,   32'h0};
    vecs[7]  = '{1'b1, 4'h0, 32'h10, 32'h0,        RAM_BUSY,   32'h0};
    vecs[8]  = '{1'b1, 4'h0, 32'h10, 32'h0,        RAM_ACCESS, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 32'h10, 32'h0,        RAM_DONE,   32'hDEADBEEF};
    vecs[10] = '{1'b0, 4'h0, 32'h10, 32'h0,        RAM_FREE,   32'hDEADBEEF};

    nrst = 1'b0;
    ren = 1'b0; wen = 4'd0; addr = 32'd0; store = 32'd0;
    ren0 = 1'b0; wen0 = 4'd0; addr0 = 32'd0; store0 = 32'd0;
    #23;
    chk("reset_state", 32'(state), 32'(RAM_FREE));
    chk("reset_load", load, 32'h0);
    chk("reset_state_lat0", 32'(state0), 32'(RAM_FREE));
    chk("reset_load_lat0", load0, 32'h0);
    #4 nrst = 1'b1;
    step();

    // Word write then read, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      ren = vecs[i].ren; wen = vecs[i].wen; addr = vecs[i].addr; store = vecs[i].store;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_load", i), load, vecs[i].ld);
      step();
    end

    // Byte strobes
    run_op(1'b0, 4'hF, 32'h20, 32'h11223344, ld);
    run_op(1'b0, 4'b0100, 32'h20, 32'hAABBCCDD, ld);
    run_op(1'b1, 4'h0, 32'h20, 32'h0, ld);
    chk("strobe_0100", ld, 32'h11BB3344);
    run_op(1'b0, 4'b1100, 32'h20, 32'h55660000, ld);
    chk("write_keeps_load", ld, 32'h11BB3344);
    run_op(1'b1, 4'h0, 32'h20, 32'h0, ld);
    chk("strobe_1100", ld, 32'h55663344);

    // Abort in second BUSY cycle
    run_op(1'b0, 4'hF, 32'h30, 32'h0, ld);
    ren = 1'b0; wen = 4'hF; addr = 32'h30; store = 32'hCAFEF00D;
    step();
    chk("abort_busy1", 32'(state), 32'(RAM_BUSY));
    step();
    chk("abort_busy2", 32'(state), 32'(RAM_BUSY));
    wen = 4'd0;
    step();
    chk("abort_free", 32'(state), 32'(RAM_FREE));
    chk("abort_load_held", load, 32'h55663344);
    step();
    run_op(1'b1, 4'h0, 32'h30, 32'h0, ld);
    chk("abort_readback", ld, 32'h0);

    // Inputs changing during BUSY are ignored
    ren = 1'b0; wen = 4'hF; addr = 32'h50; store = 32'h01020304;
    step();
    addr = 32'h54; store = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) step();
    chk("latched_done", 32'(state), 32'(RAM_DONE));
    wen = 4'd0;
    step();
    run_op(1'b1, 4'h0, 32'h50, 32'h0, ld);
    chk("latched_readback", ld, 32'h01020304);

    // Priority and alias
    run_op(1'b1, 4'hF, 32'h4000, 32'h12345678, ld);
    chk("priority_load_kept", ld, 32'h01020304);
    run_op(1'b1, 4'h0, 32'h0, 32'h0, ld);
    chk("alias_readback", ld, 32'h12345678);

    // Async reset during BUSY of a write
    run_op(1'b0, 4'hF, 32'h40, 32'h0BADCAFE, ld);
    run_op(1'b1, 4'h0, 32'h40, 32'h0, ld);
    chk("pre_reset_read", ld, 32'h0BADCAFE);
    ren = 1'b0; wen = 4'hF; addr = 32'h40; store = 32'hFFFFFFFF;
    step();
    step();
    chk("pre_reset_busy", 32'(state), 32'(RAM_BUSY));
    #3 nrst = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'(RAM_FREE));
    chk("async_reset_load", load, 32'h0);
    wen = 4'd0;
    #2 nrst = 1'b1;
    step();
    run_op(1'b1, 4'h0, 32'h40, 32'h0, ld);
    chk("post_reset_readback", ld, 32'h0BADCAFE);

    // LAT=0 back-to-back reads
    wr0(32'h0, 32'hA0A0A0A0);
    wr0(32'h4, 32'h5B5B5B5B);
    exp_st0 = '{RAM_FREE, RAM_ACCESS, RAM_DONE, RAM_FREE, RAM_ACCESS, RAM_DONE};
    exp_ld0 = '{32'h0, 32'h0, 32'hA0A0A0A0, 32'hA0A0A0A0, 32'hA0A0A0A0, 32'h5B5B5B5B};
    ren0 = 1'b1; addr0 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) addr0 = 32'h4;
      chk($sformatf("lat0_c%0d_state", i), 32'(state0), 32'(exp_st0[i]));
      chk($sformatf("lat0_c%0d_load", i), load0, exp_ld0[i]);
      step();
    end
    ren0 = 1'b0;
    step();
    chk("lat0_idle", 32'(state0), 32'(RAM_FREE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_backend.md
Name: ram_backend

Overview:
- Word-organised on-chip RAM that sits directly downstream of the AHB memory controller, on the ram side of ram_if.
- Accepts read/write requests (ren, wen byte strobes, addr, store) and models a configurable access latency.
- Reports progress on the state signal; the controller holds hreadyout low until state reads RAM_DONE.
- Provides registered read data on load.

Parameters:
- DEPTH, 4096, number of 32-bit words; must be a power of two.
- LAT, 2, wait cycles spent in RAM_BUSY before the array access (0..15).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- nrst  input  1  asynchronous, active-low reset.
- ren  input  1  read request (ram_if).
- wen  input  4  byte write strobes; bit i writes store[8i+7:8i] (ram_if).
- addr  input  32  byte address; word index is addr[$clog2(DEPTH)+1:2], higher bits ignored (aliasing), addr[1:0] ignored.
- store  input  32  write data (ram_if).
- load  output  32  read data, registered (ram_if).
- state  output  ram_state_t  RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_DONE, from common_types_pkg (ram_if).

Behaviour:
- Interface decision: one clock, clk; reset nrst is asynchronous and active-low.
- Reset: state=RAM_FREE, load=0, counter=0, latched request cleared. Array contents are not reset.
- A request is present when ren=1 or wen!=0. If both are present, the write takes priority and no read occurs.
- RAM_FREE:
  - With a request present, latch op (write if wen!=0), word index, wen and store.
  - Next state is RAM_BUSY with counter=LAT-1 when LAT>0, otherwise RAM_ACCESS.
  - With no request, stay in RAM_FREE.
- RAM_BUSY:
  - Decrement the counter each cycle; move to RAM_ACCESS when the counter is 0 (LAT BUSY cycles in total).
  - If the request drops (ren=0 and wen=0), abort to RAM_FREE. The array is untouched and load holds its value.
  - Input changes during BUSY (addr, store, wen) are ignored; the latched values are used.
- RAM_ACCESS:
  - Exactly one cycle.
  - Write: on the closing edge, write the strobed bytes of the latched store into the latched word; unstrobed bytes are preserved.
  - Read: on the closing edge, load <= array[word].
  - Always commits: the request dropping in this cycle does not abort.
  - Next state is RAM_DONE.
- RAM_DONE:
  - Exactly one cycle. Read data is valid on load.
  - For a write, load keeps its previous value.
  - Next state is always RAM_FREE, even if the request is still asserted.
  - A request still present in the RAM_FREE cycle that follows starts a new access. This matches the controller, which registers its next address phase on the DONE cycle.
- Latency:
  - Request first sampled in RAM_FREE at cycle 0; RAM_DONE is visible during cycle LAT+2.
  - Minimum issue interval is LAT+3 cycles per transfer.
- load changes only at the closing edge of RAM_ACCESS for a read, or on reset.
- Reset asserted mid-operation: state immediately returns to RAM_FREE and load to 0. A write not yet in RAM_ACCESS never reaches the array.
- Word index wraps modulo DEPTH: an address of DEPTH*4 hits word 0.
- Elaboration error if DEPTH is not a power of two or LAT>15.

Test Plan:
- Word write then read, LAT=2: ren=0, wen=1111, addr=0x10, store=0xDEADBEEF held until DONE, then ren=1 at addr=0x10 -> state FREE, BUSY, BUSY, ACCESS, DONE per op; load=0xDEADBEEF in the read's DONE cycle (cycle 4).
- Byte strobes: word 0x20 preloaded with 0x11223344; write wen=0100, store=0xAABBCCDD -> readback 0x11BB3344. Write wen=1100, store=0x5566_0000 -> readback 0x55663344.
- LAT=0 back-to-back reads: requests held continuously at 0x0 and then 0x4 -> DONE every 3rd cycle; load shows each word in its DONE cycle; no RAM_BUSY state ever appears.
- Abort: start a write at 0x30 (old value 0x0), drop wen to 0 in the second BUSY cycle -> state returns to RAM_FREE next cycle; readback of 0x30 = 0x0.
- Priority and alias, DEPTH=4096: ren=1 and wen=1111 together at addr=0x4000, store=0x12345678 -> write occurs to word 0 and load is unchanged at DONE; a later read of 0x0 returns 0x12345678.
- Async reset mid-op: assert nrst=0 between clock edges during RAM_BUSY of a write -> state=RAM_FREE and load=0 immediately; after release, the target word still holds its old value.
